// File: rtl/conv_accum_pkg.sv
// conv_accum_pkg: shared types, default widths and saturation bounds for the
// converging-index accumulator engine.
// Build option: CONV_ACCUM_SAT_EN selects saturating accumulation (see step).
package conv_accum_pkg;

  localparam int IDX_W_DEF = 8;
  localparam int ACC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  // Largest (upper=1) or smallest (upper=0) value of a w-bit signed number.
  function automatic longint sat_bound(input int w, input logic upper);
    if (upper) return (longint'(1) <<< (w - 1)) - longint'(1);
    else       return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_accum_step.sv
// conv_accum_step: one combinational iteration of the converging-index walk.
// Produces the updated accumulator and whether the walk continues (i < j).
// Build option: CONV_ACCUM_SAT_EN clamps each update to the signed ACC_W range;
// without it the accumulator wraps modulo 2^ACC_W.
module conv_accum_step
  import conv_accum_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        [IDX_W-1:0] i_i,
  input  logic        [IDX_W-1:0] j_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] next_acc_o,
  output logic                    cont_o
);

  // Saturating mode needs two guard bits so acc+t1+t2 cannot overflow before
  // the clamp; wrapping mode simply works at the accumulator width.
`ifdef CONV_ACCUM_SAT_EN
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SAT_HI = SW'(sat_bound(ACC_W, 1'b1));
  localparam logic signed [SW-1:0] SAT_LO = SW'(sat_bound(ACC_W, 1'b0));

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[ACC_W-1:0];
    else if (v < SAT_LO) return SAT_LO[ACC_W-1:0];
    else                 return v[ACC_W-1:0];
  endfunction
`else
  localparam int SW = ACC_W;
`endif

  logic        [IDX_W-1:0] j_half;
  logic signed [SW-1:0]    t1_s;
  logic signed [SW-1:0]    t2_s;
  logic signed [SW-1:0]    sum_s;

  // Data-dependent term selection and the accumulator update.
  always_comb begin
    j_half = j_i >> 1;
    if (i_i < j_half) t1_s = signed'(SW'(i_i));
    else              t1_s = -signed'(SW'(j_i));
    t2_s   = i_i[0] ? {SW{1'b1}} : SW'(1);
    sum_s  = SW'(acc_i) + t1_s + t2_s;
    cont_o = (i_i < j_i);
`ifdef CONV_ACCUM_SAT_EN
    next_acc_o = clamp(sum_s);
`else
    next_acc_o = sum_s;
`endif
  end

endmodule

// File: rtl/conv_accum_engine.sv
// conv_accum_engine: multi-cycle converging-index accumulator with valid/ready
// handshakes on input pair and result. One iteration per clock in RUN.
// Build option: CONV_ACCUM_SAT_EN (saturating accumulator, same timing).
module conv_accum_engine
  import conv_accum_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_start,
  input  logic [IDX_W-1:0] in_end,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_accum,
  output logic [IDX_W-1:0] out_iters
);

  conv_state_e              state_q, state_d;
  logic        [IDX_W-1:0]  i_q, i_d;
  logic        [IDX_W-1:0]  j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [IDX_W-1:0]  iters_q, iters_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  step_acc;
  logic                     step_cont;

  conv_accum_step #(
    .IDX_W (IDX_W),
    .ACC_W (ACC_W)
  ) u_step (
    .i_i        (i_q),
    .j_i        (j_q),
    .acc_i      (acc_q),
    .next_acc_o (step_acc),
    .cont_o     (step_cont)
  );

  // Next-state logic; clear overrides every transition and drops any result.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    iters_d     = iters_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      iters_d     = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            i_d        = in_start;
            j_d        = in_end;
            acc_d      = '0;
            iters_d    = '0;
            state_d    = RUN;
            in_ready_d = 1'b0;
          end
        end
        RUN: begin
          if (step_cont) begin
            acc_d   = step_acc;
            i_d     = i_q + 1'b1;
            j_d     = j_q - 1'b1;
            iters_d = iters_q + 1'b1;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low this cycle so no pair is taken during handoff.
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, index, accumulator and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      iters_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      iters_q     <= iters_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_accum = acc_q;
  assign out_iters = iters_q;

endmodule

// File: tb/tb_conv_accum_engine.sv
// tb_conv_accum_engine: self-checking bench for conv_accum_engine.
// Expected results come from a behavioural model of the walk, queued at
// acceptance and popped when the result appears.
module tb_conv_accum_engine;

  localparam int IDX_W = 8;
`ifdef CONV_ACCUM_SAT_EN
  localparam int ACC_W = 10;
`else
  localparam int ACC_W = 16;
`endif

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [IDX_W-1:0] iters;
    int               n;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] in_start = '0;
  logic [IDX_W-1:0] in_end = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_accum;
  logic [IDX_W-1:0] out_iters;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  conv_accum_engine #(.IDX_W(IDX_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .in_end    (in_end),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_accum (out_accum),
    .out_iters (out_iters)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference of the converging walk.
  function automatic exp_t model(input int s, input int e);
    exp_t   r;
    longint acc = 0;
    longint t1, t2;
    int     i = s, j = e, n = 0;
`ifdef CONV_ACCUM_SAT_EN
    longint hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    longint lo = -(longint'(1) <<< (ACC_W - 1));
`endif
    while (i < j) begin
      t1 = (i < (j / 2)) ? longint'(i) : -longint'(j);
      t2 = (i % 2 == 0) ? 1 : -1;
      acc = acc + t1 + t2;
`ifdef CONV_ACCUM_SAT_EN
      if (acc > hi) acc = hi;
      else if (acc < lo) acc = lo;
`endif
      i++; j--; n++;
    end
    r.acc = ACC_W'(acc);
    r.iters = IDX_W'(n);
    r.n = n;
    return r;
  endfunction

  // Offer a pair until accepted; returns the acceptance cycle or -1.
  task automatic send(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] e, output int acc_cyc);
    int w = 0;
    acc_cyc = -1;
    in_start = s; in_end = e; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    if (in_ready === 1'b1) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      sb.push_back(model(int'(s), int'(e)));
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns the cycle it was seen or -1.
  task automatic wait_out(input int budget, output int seen);
    int w = 0;
    seen = -1;
    while (out_valid !== 1'b1 && w < budget) begin @(posedge clk); #1; w++; end
    if (out_valid === 1'b1) seen = cyc;
  endtask

  // Run one job end to end and hand back what the DUT produced.
  task automatic run_job(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] e, input int budget,
                         output int lat, output logic [ACC_W-1:0] acc,
                         output logic [IDX_W-1:0] it, output exp_t ex);
    int a, c;
    lat = -1; acc = 'x; it = 'x;
    ex = '{acc: 'x, iters: 'x, n: -1};
    send(s, e, a);
    if (a >= 0) begin
      wait_out(budget, c);
      if (c >= 0) begin lat = c - a; acc = out_accum; it = out_iters; end
      if (sb.size() > 0) ex = sb.pop_front();
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_accum !== '0) $display("FAIL reset_out_accum: got %h want 0", out_accum); else n_pass++;
    n_total++; if (out_iters !== '0) $display("FAIL reset_out_iters: got %0d want 0", out_iters); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [IDX_W-1:0] ss[2], ee[2], ei[2];
    logic [ACC_W-1:0] ea[2];
    int lat; logic [ACC_W-1:0] acc; logic [IDX_W-1:0] it; exp_t ex;
    ss[0] = 3; ee[0] = 8; ea[0] = ACC_W'(-11); ei[0] = 3;
    ss[1] = 0; ee[1] = 4; ea[1] = ACC_W'(-3);  ei[1] = 2;
    for (int k = 0; k < 2; k++) begin
      run_job(ss[k], ee[k], 50, lat, acc, it, ex);
      n_total++; if (lat !== 32'(ei[k]) + 1) $display("FAIL basic%0d_latency: got %0d want %0d", k, lat, ei[k] + 1); else n_pass++;
      n_total++; if (acc !== ea[k]) $display("FAIL basic%0d_accum: got %h want %h", k, acc, ea[k]); else n_pass++;
      n_total++; if (acc !== ex.acc) $display("FAIL basic%0d_accum_sb: got %h want %h", k, acc, ex.acc); else n_pass++;
      n_total++; if (it !== ei[k]) $display("FAIL basic%0d_iters: got %0d want %0d", k, it, ei[k]); else n_pass++;
    end
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_handoff: got valid=%b ready=%b want 0 1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_zero_iter();
    logic [IDX_W-1:0] ss[2], ee[2];
    int lat; logic [ACC_W-1:0] acc; logic [IDX_W-1:0] it; exp_t ex;
    ss[0] = 5; ee[0] = 5;
    ss[1] = 10; ee[1] = 3;
    for (int k = 0; k < 2; k++) begin
      run_job(ss[k], ee[k], 20, lat, acc, it, ex);
      n_total++; if (lat !== 1) $display("FAIL zero%0d_latency: got %0d want 1", k, lat); else n_pass++;
      n_total++; if (acc !== '0) $display("FAIL zero%0d_accum: got %h want 0", k, acc); else n_pass++;
      n_total++; if (it !== '0) $display("FAIL zero%0d_iters: got %0d want 0", k, it); else n_pass++;
      n_total++; if (acc !== ex.acc || it !== ex.iters) $display("FAIL zero%0d_sb: got %h/%0d want %h/%0d", k, acc, it, ex.acc, ex.iters); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int a, c, lat;
    logic [ACC_W-1:0] acc; logic [IDX_W-1:0] it;
    exp_t ex;
    out_ready = 1'b0;
    send(3, 8, a);
    wait_out(50, c);
    n_total++; if (c < 0 || a < 0 || sb.size() == 0) $display("FAIL bp_result: got seen=%0d want a result", c); else n_pass++;
    ex = (sb.size() > 0) ? sb.pop_front() : '{acc: 'x, iters: 'x, n: -1};
    for (int k = 0; k < 20; k++) begin
      n_total++;
      if ({out_valid, in_ready, out_accum, out_iters} !== {1'b1, 1'b0, ex.acc, ex.iters})
        $display("FAIL bp_hold%0d: got v=%b r=%b acc=%h it=%0d want v=1 r=0 acc=%h it=%0d",
                 k, out_valid, in_ready, out_accum, out_iters, ex.acc, ex.iters);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    run_job(0, 4, 50, lat, acc, it, ex);
    n_total++; if (acc !== ACC_W'(-3) || it !== 8'd2) $display("FAIL bp_next: got %h/%0d want %h/2", acc, it, ACC_W'(-3)); else n_pass++;
    n_total++; if (acc !== ex.acc || lat !== ex.n + 1) $display("FAIL bp_next_sb: got %h lat %0d want %h lat %0d", acc, lat, ex.acc, ex.n + 1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int a, c, prev_a, prev_n;
    exp_t ex;
    logic [IDX_W-1:0] s, e;
    prev_a = -1; prev_n = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s = IDX_W'($urandom_range(0, 60));
      e = IDX_W'($urandom_range(0, 120));
      send(s, e, a);
      if (prev_a >= 0) begin
        n_total++; if (a - prev_a !== prev_n + 3) $display("FAIL b2b%0d_throughput: got %0d want %0d", k, a - prev_a, prev_n + 3); else n_pass++;
      end
      wait_out(100, c);
      ex = (sb.size() > 0) ? sb.pop_front() : '{acc: 'x, iters: 'x, n: -1};
      n_total++;
      if (c < 0 || out_accum !== ex.acc || out_iters !== ex.iters)
        $display("FAIL b2b%0d_result (%0d,%0d): got %h/%0d want %h/%0d", k, s, e, out_accum, out_iters, ex.acc, ex.iters);
      else n_pass++;
      prev_a = a; prev_n = ex.n;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    int a, lat; bit seen;
    logic [ACC_W-1:0] acc; logic [IDX_W-1:0] it; exp_t ex;
    send(0, 200, a);
    repeat (5) begin @(posedge clk); #1; end
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    sb.delete();
    n_total++; if (in_ready !== 1'b1) $display("FAIL clear_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL clear_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_accum !== '0 || out_iters !== '0) $display("FAIL clear_zeroed: got %h/%0d want 0/0", out_accum, out_iters); else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL clear_no_result: got out_valid=1 want 0"); else n_pass++;
    run_job(3, 8, 50, lat, acc, it, ex);
    n_total++; if (acc !== ex.acc || it !== ex.iters) $display("FAIL clear_recover: got %h/%0d want %h/%0d", acc, it, ex.acc, ex.iters); else n_pass++;
  endtask

  task automatic test_async_reset();
    int a, c;
    send(0, 200, a);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready, out_valid, out_accum, out_iters} !== {1'b1, 1'b0, {ACC_W{1'b0}}, {IDX_W{1'b0}}})
      $display("FAIL rst_run: got r=%b v=%b acc=%h it=%0d want 1 0 0 0", in_ready, out_valid, out_accum, out_iters);
    else n_pass++;
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, 8, a);
    wait_out(50, c);
    n_total++; if (c < 0 || out_accum !== ACC_W'(-11)) $display("FAIL rst_done_pre: got %h want %h", out_accum, ACC_W'(-11)); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready, out_valid, out_accum, out_iters} !== {1'b1, 1'b0, {ACC_W{1'b0}}, {IDX_W{1'b0}}})
      $display("FAIL rst_done: got r=%b v=%b acc=%h it=%0d want 1 0 0 0", in_ready, out_valid, out_accum, out_iters);
    else n_pass++;
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int lat; logic [ACC_W-1:0] acc; logic [IDX_W-1:0] it; exp_t ex;
    run_job(0, 255, 400, lat, acc, it, ex);
    n_total++; if (it !== 8'd128) $display("FAIL sat_iters: got %0d want 128", it); else n_pass++;
    n_total++; if (lat !== 129) $display("FAIL sat_latency: got %0d want 129", lat); else n_pass++;
    n_total++; if (acc !== ex.acc) $display("FAIL sat_accum_sb: got %h want %h", acc, ex.acc); else n_pass++;
`ifdef CONV_ACCUM_SAT_EN
    n_total++; if (acc !== 10'h200) $display("FAIL sat_clamp: got %h want 200", acc); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_iter();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
